// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing chain.
//   HCNT_W / RGB_W : timing counter and colour widths
//   RGB_*          : colour constants used by overlay blocks
//   vga_timing_t   : timing bundle {hcount, hsync, hblnk, vcount, vsync, vblnk}
package vga_pkg;

    localparam int HCNT_W = 11;
    localparam int RGB_W  = 12;

    localparam logic [RGB_W-1:0] RGB_BLACK  = 12'h000;
    localparam logic [RGB_W-1:0] RGB_FG_DEF = 12'h444;
    localparam logic [RGB_W-1:0] RGB_BG_DEF = 12'hE8E;

    typedef struct packed {
        logic [HCNT_W-1:0] hcount;
        logic              hsync;
        logic              hblnk;
        logic [HCNT_W-1:0] vcount;
        logic              vsync;
        logic              vblnk;
    } vga_timing_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register for the VGA timing bundle plus
// the pixel colour, asynchronous active-high reset (all stages cleared).
// Ports:
//   pclk, rst         : pixel clock, async reset
//   i_tim, i_rgb      : timing bundle and colour entering stage 1
//   o_tim, o_rgb      : same values delayed DEPTH cycles
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              pclk,
    input  logic              rst,
    input  vga_timing_t       i_tim,
    input  logic [RGB_W-1:0]  i_rgb,
    output vga_timing_t       o_tim,
    output logic [RGB_W-1:0]  o_rgb
);

    vga_timing_t      r_tim [DEPTH];
    logic [RGB_W-1:0] r_rgb [DEPTH];

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tim[i] <= '0;
                r_rgb[i] <= '0;
            end
        end else begin
            r_tim[0] <= i_tim;
            r_rgb[0] <= i_rgb;
            for (int i = 1; i < DEPTH; i++) begin
                r_tim[i] <= r_tim[i-1];
                r_rgb[i] <= r_rgb[i-1];
            end
        end
    end

    assign o_tim = r_tim[DEPTH-1];
    assign o_rgb = r_rgb[DEPTH-1];

endmodule

// File: rtl/char_overlay_pipe.sv
// char_overlay_pipe: draws a COLS x ROWS text box of FONT_W x FONT_H glyphs
// over the incoming rgb stream. Char-ROM addressing (char_xy/char_line) is
// combinational from the inputs; every other output is delayed ROM_LAT+1.
// The box position is moved through pos_x/pos_y/pos_valid and only takes
// effect on a rising edge of vblnk_in.
// Optional build macro CHAR_OVERLAY_TRANSPARENT_EN: when defined, in-box
// pixels whose glyph bit is 0 pass rgb_in instead of BG_RGB.
// Ports:
//   pclk, rst                         : pixel clock, async active-high reset
//   hcount/hsync/hblnk/vcount/vsync/vblnk/rgb _in : upstream timing + colour
//   char_pixels                       : font ROM glyph row, MSB leftmost
//   pos_x, pos_y, pos_valid, pos_busy : box position update handshake
//   *_out                             : delayed timing + composed pixel
//   char_xy, char_line                : {row,col} cell index, glyph line
module char_overlay_pipe
    import vga_pkg::*;
#(
    parameter int              COLS      = 16,
    parameter int              ROWS      = 16,
    parameter int              FONT_W    = 8,
    parameter int              FONT_H    = 16,
    parameter int              ROM_LAT   = 2,
    parameter logic [11:0]     FG_RGB    = RGB_FG_DEF,
    parameter logic [11:0]     BG_RGB    = RGB_BG_DEF,
    parameter int              POS_X_DEF = 100,
    parameter int              POS_Y_DEF = 220,
    localparam int             COL_W     = $clog2(COLS),
    localparam int             ROW_W     = $clog2(ROWS),
    localparam int             FW_W      = $clog2(FONT_W),
    localparam int             FH_W      = $clog2(FONT_H)
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic [10:0]             hcount_in,
    input  logic                    hsync_in,
    input  logic                    hblnk_in,
    input  logic [10:0]             vcount_in,
    input  logic                    vsync_in,
    input  logic                    vblnk_in,
    input  logic [11:0]             rgb_in,
    input  logic [FONT_W-1:0]       char_pixels,
    input  logic [10:0]             pos_x,
    input  logic [10:0]             pos_y,
    input  logic                    pos_valid,
    output logic                    pos_busy,
    output logic [10:0]             hcount_out,
    output logic                    hsync_out,
    output logic                    hblnk_out,
    output logic [10:0]             vcount_out,
    output logic                    vsync_out,
    output logic                    vblnk_out,
    output logic [11:0]             rgb_out,
    output logic [ROW_W+COL_W-1:0]  char_xy,
    output logic [FH_W-1:0]         char_line
);

    localparam int BOX_W = COLS * FONT_W;
    localparam int BOX_H = ROWS * FONT_H;

    // ---------------- position handshake ----------------
    logic [HCNT_W-1:0] r_ax, r_ay, r_pend_x, r_pend_y;
    logic              r_vblnk_prev;
    logic              w_vb_rise;

    assign w_vb_rise = vblnk_in & ~r_vblnk_prev;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_ax         <= HCNT_W'(POS_X_DEF);
            r_ay         <= HCNT_W'(POS_Y_DEF);
            r_pend_x     <= '0;
            r_pend_y     <= '0;
            r_vblnk_prev <= 1'b0;
            pos_busy     <= 1'b0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (w_vb_rise) begin
                // A request landing on the edge itself bypasses the pending slot.
                if (pos_valid) begin
                    r_ax <= pos_x;
                    r_ay <= pos_y;
                end else if (pos_busy) begin
                    r_ax <= r_pend_x;
                    r_ay <= r_pend_y;
                end
                pos_busy <= 1'b0;
            end else if (pos_valid) begin
                r_pend_x <= pos_x;
                r_pend_y <= pos_y;
                pos_busy <= 1'b1;
            end
        end
    end

    // ---------------- stage 0: geometry and ROM addressing ----------------
    // 12-bit compares so a box near the right/bottom edge does not wrap.
    logic                   w_in_rect;
    logic [COL_W+FW_W-1:0]  w_rx;
    logic [ROW_W+FH_W-1:0]  w_ry;

    assign w_in_rect = ({1'b0, hcount_in} >= {1'b0, r_ax}) &&
                       ({1'b0, hcount_in} <  ({1'b0, r_ax} + 12'(BOX_W))) &&
                       ({1'b0, vcount_in} >= {1'b0, r_ay}) &&
                       ({1'b0, vcount_in} <  ({1'b0, r_ay} + 12'(BOX_H)));

    // Only the low bits of the offsets are ever needed inside the box.
    assign w_rx = (COL_W+FW_W)'(hcount_in - r_ax);
    assign w_ry = (ROW_W+FH_W)'(vcount_in - r_ay);

    assign char_xy   = (w_in_rect && !rst) ?
                       {w_ry[ROW_W+FH_W-1:FH_W], w_rx[COL_W+FW_W-1:FW_W]} : '0;
    assign char_line = (w_in_rect && !rst) ? w_ry[FH_W-1:0] : '0;

    // ---------------- ROM_LAT delay ----------------
    vga_timing_t       w_tim_in, w_tim_d;
    logic [RGB_W-1:0]  w_rgb_d;

    assign w_tim_in = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};

    vga_delay_line #(.DEPTH(ROM_LAT)) u_dly (
        .pclk  (pclk),
        .rst   (rst),
        .i_tim (w_tim_in),
        .i_rgb (rgb_in),
        .o_tim (w_tim_d),
        .o_rgb (w_rgb_d)
    );

    logic            r_rect_dly [ROM_LAT];
    logic [FW_W-1:0] r_bit_dly  [ROM_LAT];

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_rect_dly[i] <= 1'b0;
                r_bit_dly[i]  <= '0;
            end
        end else begin
            r_rect_dly[0] <= w_in_rect;
            r_bit_dly[0]  <= w_rx[FW_W-1:0];
            for (int i = 1; i < ROM_LAT; i++) begin
                r_rect_dly[i] <= r_rect_dly[i-1];
                r_bit_dly[i]  <= r_bit_dly[i-1];
            end
        end
    end

    // ---------------- pixel select + output register ----------------
    logic [FONT_W-1:0] w_glyph_sh;
    logic [RGB_W-1:0]  w_rgb_sel;

    // Shifting left by the bit index brings the selected pixel to the MSB.
    assign w_glyph_sh = char_pixels << r_bit_dly[ROM_LAT-1];

    always_comb begin
        w_rgb_sel = w_rgb_d;
        if (w_tim_d.hblnk || w_tim_d.vblnk) begin
            w_rgb_sel = RGB_BLACK;
        end else if (r_rect_dly[ROM_LAT-1]) begin
            if (w_glyph_sh[FONT_W-1]) begin
                w_rgb_sel = FG_RGB;
            end else begin
`ifdef CHAR_OVERLAY_TRANSPARENT_EN
                w_rgb_sel = w_rgb_d;
`else
                w_rgb_sel = BG_RGB;
`endif
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= w_tim_d.hcount;
            hsync_out  <= w_tim_d.hsync;
            hblnk_out  <= w_tim_d.hblnk;
            vcount_out <= w_tim_d.vcount;
            vsync_out  <= w_tim_d.vsync;
            vblnk_out  <= w_tim_d.vblnk;
            rgb_out    <= w_rgb_sel;
        end
    end

endmodule

// File: tb/tb_char_overlay_pipe.sv
// tb_char_overlay_pipe: directed vectors with hand-computed expectations for
// char_overlay_pipe at default parameters (box at (100,220), 128x256).
module tb_char_overlay_pipe;

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [7:0]  char_pixels;
    logic [10:0] pos_x, pos_y;
    logic        pos_valid;
    logic        pos_busy;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef CHAR_OVERLAY_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    char_overlay_pipe dut (
        .pclk        (pclk),
        .rst         (rst),
        .hcount_in   (hcount_in),
        .hsync_in    (hsync_in),
        .hblnk_in    (hblnk_in),
        .vcount_in   (vcount_in),
        .vsync_in    (vsync_in),
        .vblnk_in    (vblnk_in),
        .rgb_in      (rgb_in),
        .char_pixels (char_pixels),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_valid   (pos_valid),
        .pos_busy    (pos_busy),
        .hcount_out  (hcount_out),
        .hsync_out   (hsync_out),
        .hblnk_out   (hblnk_out),
        .vcount_out  (vcount_out),
        .vsync_out   (vsync_out),
        .vblnk_out   (vblnk_out),
        .rgb_out     (rgb_out),
        .char_xy     (char_xy),
        .char_line   (char_line)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v,
                         input logic hs, input logic hb, input logic vs,
                         input logic vb, input logic [11:0] rgb);
        hcount_in = h;
        vcount_in = v;
        hsync_in  = hs;
        hblnk_in  = hb;
        vsync_in  = vs;
        vblnk_in  = vb;
        rgb_in    = rgb;
    endtask

    task automatic look(input logic [10:0] h, input logic [10:0] v, input logic vb,
                        input string tag, input logic [7:0] xy, input logic [3:0] ln);
        drive(h, v, 1'b0, 1'b0, 1'b0, vb, 12'h000);
        #1;
        check({tag, "_xy"}, 32'(char_xy), 32'(xy));
        check({tag, "_line"}, 32'(char_line), 32'(ln));
    endtask

    initial begin
        rst         = 1'b1;
        char_pixels = 8'h80;
        pos_x       = '0;
        pos_y       = '0;
        pos_valid   = 1'b0;
        drive(11'd110, 11'd230, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        #3;
        check("rst_rgb", 32'(rgb_out), 32'h0);
        check("rst_hcnt", 32'(hcount_out), 32'h0);
        check("rst_xy", 32'(char_xy), 32'h0);
        check("rst_busy", 32'(pos_busy), 32'h0);
        #19 rst = 1'b0;
        tick();

        // 1. addressing at default position
        look(11'd100, 11'd220, 1'b0, "t1_origin", 8'h00, 4'd0);
        look(11'd227, 11'd235, 1'b0, "t1_row0end", 8'h0F, 4'd15);
        look(11'd228, 11'd235, 1'b0, "t1_right_out", 8'h00, 4'd0);
        look(11'd227, 11'd475, 1'b0, "t1_corner", 8'hFF, 4'd15);
        look(11'd227, 11'd476, 1'b0, "t1_below_out", 8'h00, 4'd0);
        look(11'd99, 11'd220, 1'b0, "t1_left_out", 8'h00, 4'd0);

        // 2. latency and glyph select
        tick();
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick(4);
        drive(11'd100, 11'd220, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123);
        tick();
        drive(11'd101, 11'd220, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        tick();
        check("t2_early_hcnt", 32'(hcount_out), 32'd0);
        check("t2_early_hsync", 32'(hsync_out), 32'd0);
        drive(11'd99, 11'd220, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
        tick();
        check("t2_fg_rgb", 32'(rgb_out), 32'h444);
        check("t2_hcnt", 32'(hcount_out), 32'd100);
        check("t2_vcnt", 32'(vcount_out), 32'd220);
        check("t2_hsync", 32'(hsync_out), 32'd1);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();
        check("t2_bg_rgb", 32'(rgb_out), TRANSP ? 32'h123 : 32'hE8E);
        check("t2_bg_hcnt", 32'(hcount_out), 32'd101);
        tick();
        check("t2_out_rgb", 32'(rgb_out), 32'h0F0);
        check("t2_out_hcnt", 32'(hcount_out), 32'd99);
        char_pixels = 8'h01;
        drive(11'd107, 11'd220, 1'b0, 1'b0, 1'b0, 1'b0, 12'h055);
        tick(3);
        check("t2_bit7_fg", 32'(rgb_out), 32'h444);
        drive(11'd106, 11'd220, 1'b0, 1'b0, 1'b0, 1'b0, 12'h055);
        tick(3);
        check("t2_bit6_bg", 32'(rgb_out), TRANSP ? 32'h055 : 32'hE8E);
        char_pixels = 8'h80;

        // 3. blanking inside the box
        drive(11'd100, 11'd220, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0F0);
        tick(3);
        check("t3_hblnk_rgb", 32'(rgb_out), 32'h0);
        check("t3_hblnk_out", 32'(hblnk_out), 32'd1);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();

        // 4. move, applied on vblnk rising edge
        pos_x = 11'd300; pos_y = 11'd50; pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
        check("t4_busy", 32'(pos_busy), 32'd1);
        look(11'd227, 11'd235, 1'b0, "t4_old_box", 8'h0F, 4'd15);
        look(11'd324, 11'd67, 1'b0, "t4_new_not_yet", 8'h00, 4'd0);
        tick(2);
        check("t4_busy_hold", 32'(pos_busy), 32'd1);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick();
        check("t4_busy_clr", 32'(pos_busy), 32'd0);
        look(11'd324, 11'd67, 1'b1, "t4_new_box", 8'h13, 4'd1);
        look(11'd227, 11'd235, 1'b1, "t4_old_gone", 8'h00, 4'd0);
        tick();
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();

        // 5. last write wins; coincident write applies directly
        pos_x = 11'd10; pos_y = 11'd10; pos_valid = 1'b1;
        tick();
        pos_x = 11'd20; pos_y = 11'd20;
        tick();
        pos_valid = 1'b0;
        check("t5_busy", 32'(pos_busy), 32'd1);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick();
        check("t5_busy_clr", 32'(pos_busy), 32'd0);
        look(11'd28, 11'd36, 1'b1, "t5_last", 8'h11, 4'd0);
        look(11'd18, 11'd26, 1'b1, "t5_first_gone", 8'h00, 4'd0);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        pos_x = 11'd500; pos_y = 11'd400; pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
        check("t5_coinc_busy", 32'(pos_busy), 32'd0);
        look(11'd516, 11'd435, 1'b1, "t5_coinc", 8'h22, 4'd3);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();

        // 6. async reset mid-line discards pending and restores default
        rst = 1'b1;
        #3 rst = 1'b0;
        tick();
        drive(11'd110, 11'd230, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
        tick(3);
        check("t6_pre_rgb", 32'(rgb_out), TRANSP ? 32'h0F0 : 32'hE8E);
        pos_x = 11'd600; pos_y = 11'd600; pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
        check("t6_pre_busy", 32'(pos_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_rgb", 32'(rgb_out), 32'h0);
        check("t6_rst_hcnt", 32'(hcount_out), 32'h0);
        check("t6_rst_vcnt", 32'(vcount_out), 32'h0);
        check("t6_rst_busy", 32'(pos_busy), 32'h0);
        check("t6_rst_xy", 32'(char_xy), 32'h0);
        #3 rst = 1'b0;
        look(11'd227, 11'd235, 1'b0, "t6_default", 8'h0F, 4'd15);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick();
        check("t6_busy_after_vb", 32'(pos_busy), 32'd0);
        look(11'd227, 11'd235, 1'b1, "t6_no_pending", 8'h0F, 4'd15);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
